// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for one MIPS32 core.
// Holds the PC, drives instruction-memory address, latches instruction and PC+4 into IF/ID,
// honours decode stalls, ID-resolved redirects and a per-core halt request.
// Optional performance counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ID_stall,
    input  logic        branch_taken,
    input  logic        force_branch,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic [31:0] IM_Instruction,
    output logic [31:0] IM_Address,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_valid,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        act_fetch, act_stall, act_flush;

    // Target low bits are discarded: redirects are forced to word alignment.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {branch_target[31:2], 2'b00};
    // Branch operands are not valid while decode is stalled, so ignore branches then.
    assign redirect    = (branch_taken | force_branch) & ~ID_stall;

    assign IM_Address     = pc_q;
    assign ID_Instruction = instr_q;
    assign ID_PCPlus4     = pcp4_q;
    assign ID_valid       = valid_q;
    assign halted         = halted_q;

    // Next-state logic: FSM plus PC and IF/ID updates in RUN priority order.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        act_fetch = 1'b0;
        act_stall = 1'b0;
        act_flush = 1'b0;
        unique case (state_q)
            StBoot: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                state_d = halt_req ? StHalt : StRun;
            end
            StRun: begin
                if (redirect) begin
                    act_flush = 1'b1;
                    pc_d      = redirect_pc;
                    instr_d   = NOP_WORD;
                    valid_d   = 1'b0;
                    state_d   = halt_req ? StHalt : StRun;
                end else if (ID_stall) begin
                    // Full hold; a pending halt waits until the stall clears.
                    act_stall = 1'b1;
                end else if (halt_req) begin
                    // PC holds so the dropped fetch is redone on resume.
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    state_d = StHalt;
                end else begin
                    act_fetch = 1'b1;
                    pc_d      = pc_plus4;
                    instr_d   = IM_Instruction;
                    pcp4_d    = pc_plus4;
                    valid_d   = 1'b1;
                end
            end
            StHalt: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                state_d = halt_req ? StHalt : StRun;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
        halted_d = (state_d == StHalt);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pcp4_q   <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    // Saturating event counters; actions only fire in RUN.
    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        if (act_fetch && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
        if (act_stall && (stall_q != 32'hFFFF_FFFF))   stall_d   = stall_q + 32'd1;
        if (act_flush && (flush_q != 32'hFFFF_FFFF))   flush_d   = flush_q + 32'd1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetched_q <= 32'd0;
            stall_q   <= 32'd0;
            flush_q   <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
    assign perf_flush   = flush_q;
`else
    logic unused_actions;
    assign unused_actions = act_fetch ^ act_stall ^ act_flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// IM model: address 0 returns 32'h2008_0005, any other address A returns {16'hA000, A[15:0]}.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ID_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        force_branch = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] IM_Instruction;
    logic [31:0] IM_Address;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PCPlus4;
    logic        ID_valid;
    logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    assign IM_Instruction = (IM_Address == 32'd0) ? 32'h2008_0005 : {16'hA000, IM_Address[15:0]};

    fetch_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ID_stall       (ID_stall),
        .branch_taken   (branch_taken),
        .force_branch   (force_branch),
        .branch_target  (branch_target),
        .halt_req       (halt_req),
        .IM_Instruction (IM_Instruction),
        .IM_Address     (IM_Address),
        .ID_Instruction (ID_Instruction),
        .ID_PCPlus4     (ID_PCPlus4),
        .ID_valid       (ID_valid),
`ifdef FETCH_PERF_COUNTERS_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush),
`endif
        .halted         (halted)
    );

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        n_checks++; if (IM_Address !== 32'd0) begin n_fail++; $display("FAIL rst_pc got %h want %h", IM_Address, 32'd0); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ID_valid); end
        n_checks++; if (ID_Instruction !== 32'd0) begin n_fail++; $display("FAIL rst_instr got %h want 0", ID_Instruction); end
        n_checks++; if (ID_PCPlus4 !== 32'd0) begin n_fail++; $display("FAIL rst_pcp4 got %h want 0", ID_PCPlus4); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted); end
        Reset = 1'b1;
        tick(); // BOOT -> RUN, no fetch yet
        n_checks++; if (IM_Address !== 32'd0) begin n_fail++; $display("FAIL boot_pc got %h want 0", IM_Address); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", ID_valid); end
        tick(); // first fetch of PC 0
        n_checks++; if (ID_Instruction !== 32'h2008_0005) begin n_fail++; $display("FAIL first_instr got %h want 20080005", ID_Instruction); end
        n_checks++; if (ID_PCPlus4 !== 32'd4) begin n_fail++; $display("FAIL first_pcp4 got %h want 4", ID_PCPlus4); end
        n_checks++; if (IM_Address !== 32'd4) begin n_fail++; $display("FAIL first_pc got %h want 4", IM_Address); end
        n_checks++; if (ID_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", ID_valid); end
    endtask

    task automatic test_stall();
        tick(); // fetch 4, PC -> 8
        ID_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (IM_Address !== 32'd8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 8", i, IM_Address); end
            n_checks++; if (ID_Instruction !== 32'hA000_0004) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want a0000004", i, ID_Instruction); end
            n_checks++; if (ID_PCPlus4 !== 32'd8) begin n_fail++; $display("FAIL stall_pcp4[%0d] got %h want 8", i, ID_PCPlus4); end
            n_checks++; if (ID_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", i, ID_valid); end
        end
        ID_stall = 1'b0;
        tick();
        n_checks++; if (ID_Instruction !== 32'hA000_0008) begin n_fail++; $display("FAIL unstall_instr got %h want a0000008", ID_Instruction); end
        n_checks++; if (IM_Address !== 32'd12) begin n_fail++; $display("FAIL unstall_pc got %h want c", IM_Address); end
    endtask

    task automatic test_branch();
        tick(); // fetch 12, PC -> 16
        force_branch = 1'b1;
        branch_target = 32'h40;
        tick();
        n_checks++; if (IM_Address !== 32'h40) begin n_fail++; $display("FAIL jmp_pc got %h want 40", IM_Address); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_valid got %b want 0", ID_valid); end
        n_checks++; if (ID_Instruction !== 32'd0) begin n_fail++; $display("FAIL jmp_nop got %h want 0", ID_Instruction); end
        n_checks++; if (ID_PCPlus4 !== 32'h10) begin n_fail++; $display("FAIL jmp_pcp4_hold got %h want 10", ID_PCPlus4); end
        force_branch = 1'b0;
        tick();
        n_checks++; if (ID_PCPlus4 !== 32'h44) begin n_fail++; $display("FAIL tgt_pcp4 got %h want 44", ID_PCPlus4); end
        n_checks++; if (ID_Instruction !== 32'hA000_0040) begin n_fail++; $display("FAIL tgt_instr got %h want a0000040", ID_Instruction); end
        force_branch = 1'b1;
        branch_target = 32'h43;
        tick();
        n_checks++; if (IM_Address !== 32'h40) begin n_fail++; $display("FAIL align_pc got %h want 40", IM_Address); end
        force_branch = 1'b0;
    endtask

    task automatic test_stalled_branch();
        branch_taken = 1'b1;
        branch_target = 32'h80;
        ID_stall = 1'b1;
        tick();
        n_checks++; if (IM_Address !== 32'h40) begin n_fail++; $display("FAIL stbr_pc got %h want 40", IM_Address); end
        ID_stall = 1'b0;
        tick();
        n_checks++; if (IM_Address !== 32'h80) begin n_fail++; $display("FAIL br_pc got %h want 80", IM_Address); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got %b want 0", ID_valid); end
        branch_taken = 1'b0;
    endtask

    task automatic test_halt();
        force_branch = 1'b1;
        branch_target = 32'h14;
        tick();
        force_branch = 1'b0;
        halt_req = 1'b1;
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b want 1", halted); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b want 0", ID_valid); end
        n_checks++; if (IM_Address !== 32'h14) begin n_fail++; $display("FAIL halt_pc got %h want 14", IM_Address); end
        ID_stall = 1'b1;
        force_branch = 1'b1;
        branch_target = 32'h200;
        tick();
        n_checks++; if (IM_Address !== 32'h14) begin n_fail++; $display("FAIL halt_ignore_pc got %h want 14", IM_Address); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_stay got %b want 1", halted); end
        ID_stall = 1'b0;
        force_branch = 1'b0;
        halt_req = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_flag got %b want 0", halted); end
        n_checks++; if (IM_Address !== 32'h14) begin n_fail++; $display("FAIL resume_pc got %h want 14", IM_Address); end
        tick();
        n_checks++; if (ID_Instruction !== 32'hA000_0014) begin n_fail++; $display("FAIL resume_instr got %h want a0000014", ID_Instruction); end
        n_checks++; if (ID_PCPlus4 !== 32'h18) begin n_fail++; $display("FAIL resume_pcp4 got %h want 18", ID_PCPlus4); end
        n_checks++; if (ID_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid got %b want 1", ID_valid); end
        // Halt deferred by a stall
        ID_stall = 1'b1;
        halt_req = 1'b1;
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL defer_flag got %b want 0", halted); end
        n_checks++; if (ID_valid !== 1'b1) begin n_fail++; $display("FAIL defer_valid got %b want 1", ID_valid); end
        ID_stall = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL defer_halt got %b want 1", halted); end
        n_checks++; if (IM_Address !== 32'h18) begin n_fail++; $display("FAIL defer_pc got %h want 18", IM_Address); end
        halt_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        force_branch = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        force_branch = 1'b0;
        tick();
        n_checks++; if (IM_Address !== 32'd0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", IM_Address); end
        n_checks++; if (ID_PCPlus4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pcp4 got %h want 0", ID_PCPlus4); end
        n_checks++; if (ID_Instruction !== 32'hA000_FFFC) begin n_fail++; $display("FAIL wrap_instr got %h want a000fffc", ID_Instruction); end
    endtask

    task automatic test_reset_mid();
        tick(); // PC 0 -> 4, valid 1
        force_branch = 1'b1;
        branch_target = 32'h100;
        halt_req = 1'b1;
        Reset = 1'b0;
        tick();
        n_checks++; if (IM_Address !== 32'd0) begin n_fail++; $display("FAIL mrst_pc got %h want 0", IM_Address); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got %b want 0", ID_valid); end
        n_checks++; if (ID_PCPlus4 !== 32'd0) begin n_fail++; $display("FAIL mrst_pcp4 got %h want 0", ID_PCPlus4); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL mrst_halted got %b want 0", halted); end
`ifdef FETCH_PERF_COUNTERS_EN
        n_checks++; if (perf_fetched !== 32'd0) begin n_fail++; $display("FAIL mrst_pf got %h want 0", perf_fetched); end
        n_checks++; if (perf_stall !== 32'd0) begin n_fail++; $display("FAIL mrst_ps got %h want 0", perf_stall); end
        n_checks++; if (perf_flush !== 32'd0) begin n_fail++; $display("FAIL mrst_pl got %h want 0", perf_flush); end
`endif
        Reset = 1'b1;
        force_branch = 1'b0;
        tick(); // BOOT -> HALT
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL boot_halt got %b want 1", halted); end
        n_checks++; if (IM_Address !== 32'd0) begin n_fail++; $display("FAIL boot_halt_pc got %h want 0", IM_Address); end
        halt_req = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rel_halt got %b want 0", halted); end
        tick();
        n_checks++; if (ID_Instruction !== 32'h2008_0005) begin n_fail++; $display("FAIL rel_instr got %h want 20080005", ID_Instruction); end
        n_checks++; if (IM_Address !== 32'd4) begin n_fail++; $display("FAIL rel_pc got %h want 4", IM_Address); end
`ifdef FETCH_PERF_COUNTERS_EN
        n_checks++; if (perf_fetched !== 32'd1) begin n_fail++; $display("FAIL rel_pf got %h want 1", perf_fetched); end
        n_checks++; if (perf_flush !== 32'd0) begin n_fail++; $display("FAIL rel_pl got %h want 0", perf_flush); end
`endif
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_stalled_branch();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
